// File: rtl/stack_access_arbiter.sv
// Round-robin arbiter that owns the stack pointer of an external synchronous RAM stack
// and sequences PUSH/POP/PEEK for two requesters.
module stack_access_arbiter #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [1:0]    op_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic [1:0]    op_b,
  input  logic [DW-1:0] wdata_b,
  output logic          done_a,
  output logic          done_b,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [1:0] {StIdle, StExec, StWait, StResp} state_e;

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpPush = 2'b01;
  localparam logic [1:0] OpPop  = 2'b10;
  localparam logic [1:0] OpPeek = 2'b11;
  localparam logic [AW:0] Depth = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   sp_q, sp_d;
  logic          last_b_q, last_b_d;
  logic          gnt_b_q, gnt_b_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          grant_b;
  logic [AW:0]   sp_m1;

  assign full  = (sp_q == Depth);
  assign empty = (sp_q == '0);
  assign count = sp_q;
  assign sp_m1 = sp_q - 1'b1;

  // B wins only when A is idle, or on a tie when A was served last.
  assign grant_b = req_b & (~req_a | ~last_b_q);

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    last_b_d  = last_b_q;
    gnt_b_d   = gnt_b_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (req_a | req_b) begin
          gnt_b_d  = grant_b;
          last_b_d = grant_b;
          op_d     = grant_b ? op_b : op_a;
          wdata_d  = grant_b ? wdata_b : wdata_a;
          err_d    = 1'b0;
          state_d  = StExec;
        end
      end
      StExec: begin
        err_d   = 1'b0;
        state_d = StResp;
        unique case (op_q)
          OpPush: begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_addr  = sp_q[AW-1:0];
              mem_wdata = wdata_q;
              sp_d      = sp_q + 1'b1;
            end
          end
          OpPop, OpPeek: begin
            if (empty) begin
              err_d = 1'b1;
            end else begin
              mem_re   = 1'b1;
              mem_addr = sp_m1[AW-1:0];
              state_d  = StWait;
              if (op_q == OpPop) sp_d = sp_m1;
            end
          end
          OpNop: ;
        endcase
      end
      StWait: begin
        rdata_d = mem_rdata;
        state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sp_q     <= '0;
      last_b_q <= 1'b1;
      gnt_b_q  <= 1'b0;
      op_q     <= OpNop;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      last_b_q <= last_b_d;
      gnt_b_q  <= gnt_b_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign done_a = (state_q == StResp) & ~gnt_b_q;
  assign done_b = (state_q == StResp) & gnt_b_q;
  assign err    = (state_q == StResp) & err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_stack_access_arbiter.sv
// Self-checking bench for stack_access_arbiter: RAM model plus a queue-based stack reference.
module tb_stack_access_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] op_a = '0, op_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       done_a, done_b, err, mem_we, mem_re, full, empty;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [16];
  logic [7:0] model_q [$];
  logic [7:0] model_rd = '0;

  always #5 clk = ~clk;

  stack_access_arbiter #(.DW(8), .AW(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .wdata_a(wdata_a),
    .req_b(req_b), .op_b(op_b), .wdata_b(wdata_b),
    .done_a(done_a), .done_b(done_b), .err(err), .rdata(rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .count(count), .full(full), .empty(empty)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (done_a && done_b) begin
        failures++;
        $display("FAIL both_done at %0t: done_a=%b done_b=%b required not both", $time,
                 done_a, done_b);
      end
    end
  end

  // Reference stack: LIFO queue; latency 3 only for a successful POP/PEEK.
  task automatic model_apply(input logic [1:0] op, input logic [7:0] d, output logic x_err,
                             output int x_lat, output int x_we, output int x_re,
                             output logic [3:0] x_addr);
    x_err = 1'b0; x_lat = 2; x_we = 0; x_re = 0; x_addr = '0;
    case (op)
      2'd1: if (model_q.size() == 16) x_err = 1'b1;
            else begin x_addr = 4'(model_q.size()); model_q.push_back(d); x_we = 1; end
      2'd2, 2'd3: if (model_q.size() == 0) x_err = 1'b1;
            else begin
              x_addr = 4'(model_q.size() - 1); x_re = 1; x_lat = 3;
              model_rd = (op == 2'd2) ? model_q.pop_back() : model_q[$];
            end
      default: ;
    endcase
  endtask

  task automatic run_op(input bit who_b, input logic [1:0] op, input logic [7:0] d,
                        output int lat, output logic e, output logic [7:0] rd,
                        output int n_we, output int n_re, output logic [3:0] addr,
                        output logic [7:0] wd, output bit wrong_done);
    lat = 0; e = 1'b0; rd = '0; n_we = 0; n_re = 0; addr = '0; wd = '0; wrong_done = 1'b0;
    @(negedge clk);
    if (who_b) begin req_b = 1'b1; op_b = op; wdata_b = d; end
    else begin req_a = 1'b1; op_a = op; wdata_a = d; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_we || mem_re) begin addr = mem_addr; wd = mem_wdata; end
      if (mem_we) n_we++;
      if (mem_re) n_re++;
      if (who_b ? done_a : done_b) wrong_done = 1'b1;
      if (who_b ? done_b : done_a) begin lat = k; e = err; rd = rdata; break; end
    end
    if (who_b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    model_rd = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    req_a = 1'b1; op_a = 2'd1; wdata_a = 8'h77;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin
      failures++; $display("FAIL pre_abort_we: got %b want 1", mem_we);
    end
    #2 rst = 1'b1; req_a = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++; $display("FAIL abort_we: got %b want 0", mem_we);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({done_a, done_b, mem_we, mem_re} !== 4'b0 || count !== 5'd0 || empty !== 1'b1 ||
          full !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: done=%b%b we=%b re=%b count=%0d empty=%b full=%b want 0s/0/1/0",
                 done_a, done_b, mem_we, mem_re, count, empty, full);
      end
    end
  endtask

  task automatic test_push_pop();
    int lat, nwe, nre; logic e, wdone; logic [7:0] rd, wd; logic [3:0] ad;
    do_reset();
    run_op(1'b0, 2'd1, 8'h5A, lat, e, rd, nwe, nre, ad, wd, wdone);
    checks++;
    if (lat !== 2 || e !== 1'b0 || nwe !== 1 || ad !== 4'd0 || wd !== 8'h5A || count !== 5'd1) begin
      failures++;
      $display("FAIL push_5a: lat=%0d err=%b we=%0d addr=%0d wd=%h count=%0d want 2/0/1/0/5a/1",
               lat, e, nwe, ad, wd, count);
    end
    run_op(1'b0, 2'd2, 8'h00, lat, e, rd, nwe, nre, ad, wd, wdone);
    checks++;
    if (lat !== 3 || e !== 1'b0 || nre !== 1 || ad !== 4'd0 || rd !== 8'h5A || count !== 5'd0 ||
        empty !== 1'b1) begin
      failures++;
      $display("FAIL pop_5a: lat=%0d err=%b re=%0d addr=%0d rd=%h count=%0d want 3/0/1/0/5a/0",
               lat, e, nre, ad, rd, count);
    end
  endtask

  task automatic test_overflow_underflow();
    int lat, nwe, nre, xl, xwe, xre; logic e, wdone, xe; logic [7:0] rd, wd, dat;
    logic [3:0] ad, xa;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dat = 8'($urandom);
      model_apply(2'd1, dat, xe, xl, xwe, xre, xa);
      run_op(i[0], 2'd1, dat, lat, e, rd, nwe, nre, ad, wd, wdone);
    end
    run_op(1'b0, 2'd1, 8'hEE, lat, e, rd, nwe, nre, ad, wd, wdone);
    checks++;
    if (e !== 1'b1 || nwe !== 0 || lat !== 2 || count !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("FAIL overflow: err=%b we=%0d lat=%0d count=%0d full=%b want 1/0/2/16/1",
               e, nwe, lat, count, full);
    end
    for (int i = 0; i < 16; i++) begin
      model_apply(2'd2, 8'h00, xe, xl, xwe, xre, xa);
      run_op(1'b1, 2'd2, 8'h00, lat, e, rd, nwe, nre, ad, wd, wdone);
      checks++;
      if (rd !== model_rd || e !== 1'b0 || ad !== xa || count !== 5'(model_q.size())) begin
        failures++;
        $display("FAIL drain_%0d: rd=%h err=%b addr=%0d count=%0d want %h/0/%0d/%0d", i, rd, e,
                 ad, count, model_rd, xa, model_q.size());
      end
    end
    for (int k = 2; k <= 3; k++) begin
      run_op(k[0], 2'(k), 8'h00, lat, e, rd, nwe, nre, ad, wd, wdone);
      checks++;
      if (e !== 1'b1 || nre !== 0 || lat !== 2 || rd !== model_rd || count !== 5'd0) begin
        failures++;
        $display("FAIL underflow_op%0d: err=%b re=%0d lat=%0d rd=%h count=%0d want 1/0/2/%h/0",
                 k, e, nre, lat, rd, count, model_rd);
      end
    end
  endtask

  task automatic test_random();
    int lat, nwe, nre, xl, xwe, xre; logic e, wdone, xe; logic [7:0] rd, wd, dat;
    logic [3:0] ad, xa; logic [1:0] op; bit who;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      who = 1'($urandom);
      op = ($urandom_range(0, 9) < 5) ? 2'd1 : 2'($urandom_range(0, 3));
      dat = 8'($urandom);
      model_apply(op, dat, xe, xl, xwe, xre, xa);
      run_op(who, op, dat, lat, e, rd, nwe, nre, ad, wd, wdone);
      checks++;
      if (lat !== xl || e !== xe || rd !== model_rd || nwe !== xwe || nre !== xre ||
          ((xwe + xre) != 0 && ad !== xa) || (xwe != 0 && wd !== dat) ||
          count !== 5'(model_q.size()) || wdone) begin
        failures++;
        $display("FAIL rand_%0d op=%0d who=%0d: lat=%0d err=%b rd=%h we=%0d re=%0d addr=%0d cnt=%0d wrong_done=%b want %0d/%b/%h/%0d/%0d/%0d/%0d/0",
                 i, op, who, lat, e, rd, nwe, nre, ad, count, wdone, xl, xe, model_rd, xwe,
                 xre, xa, model_q.size());
      end
    end
  endtask

  task automatic test_contention();
    int order [$]; int xl, xwe, xre; logic xe; logic [3:0] xa;
    bit rearm_a = 1'b0, rearm_b = 1'b0;
    rst = 1'b1;
    req_a = 1'b1; op_a = 2'd1; wdata_a = 8'($urandom);
    req_b = 1'b1; op_b = 2'd1; wdata_b = 8'($urandom);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_q.delete(); model_rd = '0;
    for (int cyc = 0; cyc < 200 && order.size() < 8; cyc++) begin
      @(negedge clk);
      if (rearm_a) begin req_a = 1'b1; op_a = 2'($urandom); wdata_a = 8'($urandom); rearm_a = 0; end
      if (rearm_b) begin req_b = 1'b1; op_b = 2'($urandom); wdata_b = 8'($urandom); rearm_b = 0; end
      for (int r = 0; r < 2; r++) begin
        if (r == 0 ? done_a : done_b) begin
          order.push_back(r);
          model_apply(r == 0 ? op_a : op_b, r == 0 ? wdata_a : wdata_b, xe, xl, xwe, xre, xa);
          checks++;
          if (err !== xe || rdata !== model_rd || count !== 5'(model_q.size())) begin
            failures++;
            $display("FAIL contend_done_%0d: err=%b rd=%h count=%0d want %b/%h/%0d",
                     order.size(), err, rdata, count, xe, model_rd, model_q.size());
          end
          if (r == 0) begin req_a = 1'b0; rearm_a = 1'b1; end
          else begin req_b = 1'b0; rearm_b = 1'b1; end
        end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    checks++;
    if (order.size() != 8) begin
      failures++; $display("FAIL contend_count: got %0d dones want 8", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != (i % 2)) begin
        failures++; $display("FAIL contend_order_%0d: got %0d want %0d", i, order[i], i % 2);
      end
    end
  endtask

  task automatic test_peek_shared();
    int lat, nwe, nre; logic e, wdone; logic [7:0] rd, wd; logic [3:0] ad;
    do_reset();
    run_op(1'b0, 2'd1, 8'h11, lat, e, rd, nwe, nre, ad, wd, wdone);
    run_op(1'b0, 2'd1, 8'h22, lat, e, rd, nwe, nre, ad, wd, wdone);
    run_op(1'b1, 2'd3, 8'h00, lat, e, rd, nwe, nre, ad, wd, wdone);
    checks++;
    if (rd !== 8'h22 || e !== 1'b0 || lat !== 3 || ad !== 4'd1 || count !== 5'd2 || wdone) begin
      failures++;
      $display("FAIL peek_b: rd=%h err=%b lat=%0d addr=%0d count=%0d wrong_done=%b want 22/0/3/1/2/0",
               rd, e, lat, ad, count, wdone);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow_underflow();
    test_random();
    test_contention();
    test_peek_shared();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
